// File: rtl/pe_pkg.sv
// Shared definitions for the SC-CGRA PE datapath.
// Contents:
//   OP_*          ALU opcodes (4-bit). Any 4'b111x opcode is a multiply.
//   is_mul()      true for either multiply encoding
//   stage_state_t issue-stage FSM states
package pe_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   // Reverse subtract: result is b - a.
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_SRL = 4'b0010;
   localparam logic [3:0] OP_SLL = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0100;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_SRA = 4'b1010;
   localparam logic [3:0] OP_MUL = 4'b1110;

   // The multiplier ignores the opcode LSB.
   function automatic logic is_mul(input logic [3:0] op);
      return op[3:1] == 3'b111;
   endfunction

   typedef enum logic [1:0] {
      ST_UNCFG = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } stage_state_t;

endpackage

// File: rtl/pe_alu_issue_stage_if.sv
// Bus bundle of the PE ALU issue stage.
// Groups the config bus, both operand channels, the ALU-facing signals, the
// result channel and the fire counter.
//   slave  : the issue stage's view
//   master : the surrounding PE / environment's view
interface pe_alu_issue_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 32,
   parameter int CFG_WIDTH  = 4,
   parameter int CNT_WIDTH  = 16
);

   logic                  io_cfg_valid;
   logic [CFG_WIDTH-1:0]  io_cfg_op;
   logic                  io_cfg_const_en;
   logic [DATA_WIDTH-1:0] io_cfg_const;

   logic                  io_a_valid;
   logic                  io_a_ready;
   logic [DATA_WIDTH-1:0] io_a_bits;

   logic                  io_b_valid;
   logic                  io_b_ready;
   logic [DATA_WIDTH-1:0] io_b_bits;

   logic                  io_alu_en;
   logic [DATA_WIDTH-1:0] io_alu_a;
   logic [DATA_WIDTH-1:0] io_alu_b;
   logic [CFG_WIDTH-1:0]  io_alu_cfg;
   logic [OUT_WIDTH-1:0]  io_alu_result;

   logic                  io_out_valid;
   logic                  io_out_ready;
   logic [OUT_WIDTH-1:0]  io_out_bits;

   logic [CNT_WIDTH-1:0]  io_fire_count;

   modport slave (
      input  io_cfg_valid, io_cfg_op, io_cfg_const_en, io_cfg_const,
      input  io_a_valid, io_a_bits, io_b_valid, io_b_bits,
      input  io_alu_result, io_out_ready,
      output io_a_ready, io_b_ready,
      output io_alu_en, io_alu_a, io_alu_b, io_alu_cfg,
      output io_out_valid, io_out_bits, io_fire_count
   );

   modport master (
      output io_cfg_valid, io_cfg_op, io_cfg_const_en, io_cfg_const,
      output io_a_valid, io_a_bits, io_b_valid, io_b_bits,
      output io_alu_result, io_out_ready,
      input  io_a_ready, io_b_ready,
      input  io_alu_en, io_alu_a, io_alu_b, io_alu_cfg,
      input  io_out_valid, io_out_bits, io_fire_count
   );

endinterface

// File: rtl/pe_alu_issue_stage_slot.sv
// pe_operand_slot: 1-entry valid/ready holding register for one ALU operand.
// Ports:
//   clock, reset_n     clock and asynchronous active-low reset
//   enable             slot may accept beats (stage configured, slot streamed)
//   in_valid/in_bits   upstream beat
//   consume            the stage fires this cycle and takes the held operand
//   flush              drop the held operand
//   ready              upstream ready
//   full, bits         held operand
module pe_operand_slot #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_bits,
   input  logic             consume,
   input  logic             flush,
   output logic             ready,
   output logic             full,
   output logic [WIDTH-1:0] bits
);

   logic             full_q;
   logic [WIDTH-1:0] data_q;
   logic             accept;

   // A slot being emptied by a fire can take a new beat in the same cycle,
   // which is what lets the stage sustain one result per cycle.
   assign ready  = enable & (!full_q | consume);
   assign accept = in_valid & ready;
   assign full   = full_q;
   assign bits   = data_q;

   // A new beat wins over the clear, so a fire with a simultaneous arrival
   // leaves the slot full with the newer operand.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else if (accept) begin
         full_q <= 1'b1;
         data_q <= in_bits;
      end else if (consume | flush) begin
         full_q <= 1'b0;
      end
   end

endmodule

// File: rtl/pe_alu_issue_stage.sv
// pe_alu_issue_stage: operand-collect / issue stage upstream of the PE ALU.
// Collects operands A and B on their own valid/ready channels (B may instead
// be a configured constant), fires the external combinational ALU once both
// are present and the result register can take a value, and registers the
// ALU result into a 1-entry valid/ready output.
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      pe_alu_issue_stage_if.slave: config bus, operand channels A/B,
//            ALU enable/operands/opcode/result, result channel, fire counter
module pe_alu_issue_stage
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 32,
   parameter int CFG_WIDTH  = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   pe_alu_issue_stage_if.slave  bus
);

   stage_state_t          state, state_next;
   logic [CFG_WIDTH-1:0]  op;
   logic                  const_en;
   logic [DATA_WIDTH-1:0] const_val;

   logic                  a_full, b_full, b_full_eff;
   logic [DATA_WIDTH-1:0] a_bits, b_bits;
   logic                  configured, fire;

   logic                  out_valid;
   logic [OUT_WIDTH-1:0]  out_bits;
   logic [CNT_WIDTH-1:0]  fire_count;

   assign configured = (state != ST_UNCFG);

   pe_operand_slot #(.WIDTH(DATA_WIDTH)) u_slot_a (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (configured),
      .in_valid (bus.io_a_valid),
      .in_bits  (bus.io_a_bits),
      .consume  (fire),
      .flush    (1'b0),
      .ready    (bus.io_a_ready),
      .full     (a_full),
      .bits     (a_bits)
   );

   // In constant mode slot B is closed to the stream; leaving constant mode
   // starts B empty so a stale streamed value is never paired with A.
   pe_operand_slot #(.WIDTH(DATA_WIDTH)) u_slot_b (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (configured & !const_en),
      .in_valid (bus.io_b_valid),
      .in_bits  (bus.io_b_bits),
      .consume  (fire & !const_en),
      .flush    (bus.io_cfg_valid & !bus.io_cfg_const_en),
      .ready    (bus.io_b_ready),
      .full     (b_full),
      .bits     (b_bits)
   );

   assign b_full_eff = const_en | b_full;

   // Fire whenever both operands are held and the result register is empty
   // or being drained this cycle.
   assign fire = configured & a_full & b_full_eff & (!out_valid | bus.io_out_ready);

   assign bus.io_alu_en     = fire;
   assign bus.io_alu_a      = fire ? a_bits : '0;
   assign bus.io_alu_b      = fire ? (const_en ? const_val : b_bits) : '0;
   assign bus.io_alu_cfg    = op;
   assign bus.io_out_valid  = out_valid;
   assign bus.io_out_bits   = out_bits;
   assign bus.io_fire_count = fire_count;

   // Config registers load on every write in any state; the ALU sees the new
   // opcode only from the following cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op        <= '0;
         const_en  <= 1'b0;
         const_val <= '0;
      end else if (bus.io_cfg_valid) begin
         op        <= bus.io_cfg_op;
         const_en  <= bus.io_cfg_const_en;
         const_val <= bus.io_cfg_const;
      end
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= ST_UNCFG;
      else          state <= state_next;
   end

   // STALL marks a registered result the sink has not yet taken.
   always_comb begin
      state_next = state;
      case (state)
         ST_UNCFG: if (bus.io_cfg_valid)               state_next = ST_RUN;
         ST_RUN:   if (fire && !bus.io_out_ready)      state_next = ST_STALL;
         ST_STALL: if (bus.io_out_ready)               state_next = ST_RUN;
         default:                                      state_next = ST_UNCFG;
      endcase
   end

   // Result register: a fire reloads it even when the sink pops in the same
   // cycle, so a continuous stream never shows a bubble.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         out_bits   <= '0;
         fire_count <= '0;
      end else if (fire) begin
         out_valid  <= 1'b1;
         out_bits   <= bus.io_alu_result;
         fire_count <= fire_count + 1'b1;
      end else if (bus.io_out_ready) begin
         out_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pe_alu_issue_stage.sv
// Directed bench for pe_alu_issue_stage with a behavioural ALU attached.
module tb_pe_alu_issue_stage;
   import pe_pkg::*;

   logic clock;
   logic reset_n;
   int   checks;
   int   errors;

   pe_alu_issue_stage_if bus ();

   pe_alu_issue_stage dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural stand-in for the PE ALU.
   always_comb begin
      bus.io_alu_result = '0;
      case (bus.io_alu_cfg)
         OP_ADD: bus.io_alu_result = bus.io_alu_a + bus.io_alu_b;
         OP_SUB: bus.io_alu_result = bus.io_alu_b - bus.io_alu_a;
         OP_SRL: bus.io_alu_result = bus.io_alu_a >> bus.io_alu_b[5:0];
         OP_SLL: bus.io_alu_result = bus.io_alu_a << bus.io_alu_b[5:0];
         OP_AND: bus.io_alu_result = bus.io_alu_a & bus.io_alu_b;
         OP_XOR: bus.io_alu_result = bus.io_alu_a ^ bus.io_alu_b;
         OP_OR:  bus.io_alu_result = bus.io_alu_a | bus.io_alu_b;
         OP_SRA: bus.io_alu_result = $signed(bus.io_alu_a) >>> bus.io_alu_b[5:0];
         default: if (is_mul(bus.io_alu_cfg)) bus.io_alu_result = bus.io_alu_a * bus.io_alu_b;
      endcase
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_cfg(input logic [3:0] op, input logic cen, input logic [31:0] cval);
      bus.io_cfg_valid    = 1'b1;
      bus.io_cfg_op       = op;
      bus.io_cfg_const_en = cen;
      bus.io_cfg_const    = cval;
      step();
      bus.io_cfg_valid    = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.io_cfg_valid = 0; bus.io_cfg_op = 0; bus.io_cfg_const_en = 0; bus.io_cfg_const = 0;
      bus.io_a_valid = 0; bus.io_a_bits = 0; bus.io_b_valid = 0; bus.io_b_bits = 0;
      bus.io_out_ready = 1;
      step(); step();
      checks++; if (bus.io_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %0b expected 0", bus.io_out_valid); end
      checks++; if (bus.io_out_bits !== 32'd0) begin errors++; $display("[TB] FAIL rst_out_bits got %0d expected 0", bus.io_out_bits); end
      checks++; if (bus.io_fire_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_count got %0d expected 0", bus.io_fire_count); end
      checks++; if (bus.io_alu_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_alu_en got %0b expected 0", bus.io_alu_en); end
      checks++; if (bus.io_alu_cfg !== 4'd0) begin errors++; $display("[TB] FAIL rst_alu_cfg got %0d expected 0", bus.io_alu_cfg); end
      reset_n = 1'b1;
      bus.io_a_valid = 1; bus.io_b_valid = 1;
      #1;
      checks++; if (bus.io_a_ready !== 1'b0 || bus.io_b_ready !== 1'b0) begin errors++; $display("[TB] FAIL uncfg_ready got %0b%0b expected 00", bus.io_a_ready, bus.io_b_ready); end
      step();
      bus.io_a_valid = 0; bus.io_b_valid = 0;
   endtask

   task automatic test_add();
      do_cfg(OP_ADD, 1'b0, 32'd0);
      bus.io_a_valid = 1; bus.io_a_bits = 5; bus.io_b_valid = 1; bus.io_b_bits = 7;
      #1;
      checks++; if (bus.io_a_ready !== 1'b1 || bus.io_b_ready !== 1'b1) begin errors++; $display("[TB] FAIL add_ready got %0b%0b expected 11", bus.io_a_ready, bus.io_b_ready); end
      checks++; if (bus.io_alu_en !== 1'b0) begin errors++; $display("[TB] FAIL add_early_en got %0b expected 0", bus.io_alu_en); end
      step();
      bus.io_a_valid = 0; bus.io_b_valid = 0;
      #1;
      checks++; if (bus.io_alu_en !== 1'b1 || bus.io_alu_a !== 32'd5 || bus.io_alu_b !== 32'd7) begin errors++; $display("[TB] FAIL add_fire got en=%0b a=%0d b=%0d expected en=1 a=5 b=7", bus.io_alu_en, bus.io_alu_a, bus.io_alu_b); end
      step();
      checks++; if (bus.io_out_valid !== 1'b1 || bus.io_out_bits !== 32'd12) begin errors++; $display("[TB] FAIL add_result got v=%0b %0d expected v=1 12", bus.io_out_valid, bus.io_out_bits); end
      checks++; if (bus.io_fire_count !== 16'd1 || bus.io_alu_en !== 1'b0) begin errors++; $display("[TB] FAIL add_count got cnt=%0d en=%0b expected cnt=1 en=0", bus.io_fire_count, bus.io_alu_en); end
      step();
      checks++; if (bus.io_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL add_pop got %0b expected 0", bus.io_out_valid); end
   endtask

   task automatic test_sub_skew();
      do_cfg(OP_SUB, 1'b0, 32'd0);
      bus.io_a_valid = 1; bus.io_a_bits = 3;
      step();
      bus.io_a_valid = 0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.io_alu_en !== 1'b0 || bus.io_a_ready !== 1'b0) begin errors++; $display("[TB] FAIL sub_wait%0d got en=%0b a_ready=%0b expected 0 0", i, bus.io_alu_en, bus.io_a_ready); end
         step();
      end
      bus.io_b_valid = 1; bus.io_b_bits = 10;
      #1;
      checks++; if (bus.io_b_ready !== 1'b1) begin errors++; $display("[TB] FAIL sub_b_ready got %0b expected 1", bus.io_b_ready); end
      step();
      bus.io_b_valid = 0;
      #1;
      checks++; if (bus.io_alu_en !== 1'b1) begin errors++; $display("[TB] FAIL sub_fire got %0b expected 1", bus.io_alu_en); end
      step();
      checks++; if (bus.io_out_bits !== 32'd7 || bus.io_fire_count !== 16'd2) begin errors++; $display("[TB] FAIL sub_result got %0d cnt=%0d expected 7 cnt=2", bus.io_out_bits, bus.io_fire_count); end
   endtask

   task automatic test_backpressure();
      do_cfg(OP_ADD, 1'b0, 32'd0);
      bus.io_out_ready = 0;
      bus.io_a_valid = 1; bus.io_a_bits = 1; bus.io_b_valid = 1; bus.io_b_bits = 1;
      step();
      bus.io_a_bits = 2; bus.io_b_bits = 2;
      #1;
      checks++; if (bus.io_alu_en !== 1'b1) begin errors++; $display("[TB] FAIL bp_fire1 got %0b expected 1", bus.io_alu_en); end
      step();
      bus.io_a_valid = 0; bus.io_b_valid = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (bus.io_out_valid !== 1'b1 || bus.io_out_bits !== 32'd2) begin errors++; $display("[TB] FAIL bp_hold%0d got v=%0b %0d expected v=1 2", i, bus.io_out_valid, bus.io_out_bits); end
         checks++; if (bus.io_a_ready !== 1'b0 || bus.io_b_ready !== 1'b0 || bus.io_alu_en !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall%0d got ar=%0b br=%0b en=%0b expected 0 0 0", i, bus.io_a_ready, bus.io_b_ready, bus.io_alu_en); end
         step();
      end
      bus.io_out_ready = 1;
      #1;
      checks++; if (bus.io_alu_en !== 1'b1 || bus.io_alu_a !== 32'd2 || bus.io_out_bits !== 32'd2) begin errors++; $display("[TB] FAIL bp_release got en=%0b a=%0d out=%0d expected en=1 a=2 out=2", bus.io_alu_en, bus.io_alu_a, bus.io_out_bits); end
      step();
      checks++; if (bus.io_out_valid !== 1'b1 || bus.io_out_bits !== 32'd4) begin errors++; $display("[TB] FAIL bp_second got v=%0b %0d expected v=1 4", bus.io_out_valid, bus.io_out_bits); end
      step();
      checks++; if (bus.io_out_valid !== 1'b0 || bus.io_fire_count !== 16'd4) begin errors++; $display("[TB] FAIL bp_drain got v=%0b cnt=%0d expected v=0 cnt=4", bus.io_out_valid, bus.io_fire_count); end
   endtask

   task automatic test_const_stream();
      logic [31:0] exp_out [3];
      exp_out[0] = 32'd8; exp_out[1] = 32'd16; exp_out[2] = 32'd32;
      do_cfg(OP_SLL, 1'b1, 32'd3);
      bus.io_a_valid = 1; bus.io_a_bits = 1;
      #1;
      checks++; if (bus.io_b_ready !== 1'b0 || bus.io_a_ready !== 1'b1) begin errors++; $display("[TB] FAIL const_ready got ar=%0b br=%0b expected 1 0", bus.io_a_ready, bus.io_b_ready); end
      step();
      bus.io_a_bits = 2;
      #1;
      checks++; if (bus.io_alu_en !== 1'b1 || bus.io_alu_b !== 32'd3) begin errors++; $display("[TB] FAIL const_fire got en=%0b b=%0d expected en=1 b=3", bus.io_alu_en, bus.io_alu_b); end
      for (int i = 0; i < 3; i++) begin
         step();
         if (i == 0) bus.io_a_bits = 4;
         else        bus.io_a_valid = 0;
         checks++; if (bus.io_out_valid !== 1'b1 || bus.io_out_bits !== exp_out[i] || bus.io_b_ready !== 1'b0) begin errors++; $display("[TB] FAIL const_out%0d got v=%0b %0d br=%0b expected v=1 %0d br=0", i, bus.io_out_valid, bus.io_out_bits, bus.io_b_ready, exp_out[i]); end
      end
      checks++; if (bus.io_fire_count !== 16'd7) begin errors++; $display("[TB] FAIL const_count got %0d expected 7", bus.io_fire_count); end
   endtask

   task automatic test_reset_midop();
      do_cfg(OP_ADD, 1'b1, 32'd1);
      bus.io_out_ready = 0;
      bus.io_a_valid = 1; bus.io_a_bits = 5;
      step();
      bus.io_a_bits = 7;
      step();
      bus.io_a_valid = 0;
      #1;
      checks++; if (bus.io_out_valid !== 1'b1 || bus.io_out_bits !== 32'd6 || bus.io_alu_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_setup got v=%0b %0d en=%0b expected v=1 6 en=0", bus.io_out_valid, bus.io_out_bits, bus.io_alu_en); end
      #1 reset_n = 1'b0;
      #1;
      checks++; if (bus.io_out_valid !== 1'b0 || bus.io_out_bits !== 32'd0 || bus.io_fire_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_rst_out got v=%0b %0d cnt=%0d expected 0 0 0", bus.io_out_valid, bus.io_out_bits, bus.io_fire_count); end
      checks++; if (bus.io_alu_en !== 1'b0 || bus.io_alu_a !== 32'd0 || bus.io_a_ready !== 1'b0 || bus.io_alu_cfg !== 4'd0) begin errors++; $display("[TB] FAIL mid_rst_alu got en=%0b a=%0d ar=%0b cfg=%0d expected 0 0 0 0", bus.io_alu_en, bus.io_alu_a, bus.io_a_ready, bus.io_alu_cfg); end
      step();
      reset_n = 1'b1;
      bus.io_out_ready = 1;
      bus.io_a_valid = 1; bus.io_a_bits = 1; bus.io_b_valid = 1; bus.io_b_bits = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.io_a_ready !== 1'b0 || bus.io_b_ready !== 1'b0 || bus.io_alu_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_uncfg%0d got ar=%0b br=%0b en=%0b expected 0 0 0", i, bus.io_a_ready, bus.io_b_ready, bus.io_alu_en); end
         step();
      end
      checks++; if (bus.io_out_valid !== 1'b0 || bus.io_fire_count !== 16'd0) begin errors++; $display("[TB] FAIL mid_idle got v=%0b cnt=%0d expected 0 0", bus.io_out_valid, bus.io_fire_count); end
      bus.io_a_valid = 0; bus.io_b_valid = 0;
   endtask

   task automatic test_cfg_during_fire();
      do_cfg(OP_ADD, 1'b0, 32'd0);
      bus.io_a_valid = 1; bus.io_a_bits = 6; bus.io_b_valid = 1; bus.io_b_bits = 3;
      step();
      bus.io_a_valid = 0; bus.io_b_valid = 0;
      bus.io_cfg_valid = 1; bus.io_cfg_op = OP_XOR; bus.io_cfg_const_en = 0;
      #1;
      checks++; if (bus.io_alu_en !== 1'b1 || bus.io_alu_cfg !== OP_ADD) begin errors++; $display("[TB] FAIL cfgfire_op got en=%0b cfg=%0d expected en=1 cfg=0", bus.io_alu_en, bus.io_alu_cfg); end
      step();
      bus.io_cfg_valid = 0;
      checks++; if (bus.io_out_bits !== 32'd9 || bus.io_alu_cfg !== OP_XOR) begin errors++; $display("[TB] FAIL cfgfire_res got %0d cfg=%0d expected 9 cfg=5", bus.io_out_bits, bus.io_alu_cfg); end
      bus.io_a_valid = 1; bus.io_a_bits = 6; bus.io_b_valid = 1; bus.io_b_bits = 3;
      step();
      bus.io_a_valid = 0; bus.io_b_valid = 0;
      step();
      checks++; if (bus.io_out_valid !== 1'b1 || bus.io_out_bits !== 32'd5 || bus.io_fire_count !== 16'd2) begin errors++; $display("[TB] FAIL cfgfire_xor got v=%0b %0d cnt=%0d expected v=1 5 cnt=2", bus.io_out_valid, bus.io_out_bits, bus.io_fire_count); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_add();
      test_sub_skew();
      test_backpressure();
      test_const_stream();
      test_reset_midop();
      test_cfg_during_fire();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
